// File: rtl/demux_4way_reg.sv
// -----------------------------------------------------------------------------
// demux_4way_reg
//   Registered 1-to-4 demultiplexer. A single valid/ready byte stream is
//   steered by `select` into one of four one-entry output registers. Each
//   output channel has its own valid/ready handshake towards an independent
//   consumer. A free-running counter tracks how many words the consumers
//   have taken across all channels.
//
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high reset
//   select     in   2          destination channel (0..3 -> output_1..output_4)
//   in_valid   in   1          upstream word present on in_data
//   in_data    in   WIDTH      upstream word
//   in_ready   out  1          selected channel can take a word this cycle
//   output_1   out  WIDTH      channel 1 register contents
//   output_2   out  WIDTH      channel 2 register contents
//   output_3   out  WIDTH      channel 3 register contents
//   output_4   out  WIDTH      channel 4 register contents
//   out_valid  out  4          bit k-1: channel k holds an unconsumed word
//   out_ready  in   4          bit k-1: channel k consumer takes the word
//   delivered  out  CNT_WIDTH  words consumed downstream, wraps modulo 2^N
// -----------------------------------------------------------------------------
module demux_4way_reg #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           select,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     output_1,
    output logic [WIDTH-1:0]     output_2,
    output logic [WIDTH-1:0]     output_3,
    output logic [WIDTH-1:0]     output_4,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [CNT_WIDTH-1:0] delivered
);

    logic [WIDTH-1:0]     data_q [4];
    logic [WIDTH-1:0]     data_d [4];
    logic [3:0]           valid_q;
    logic [3:0]           valid_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic       accept;
    logic [3:0] consume;
    logic [3:0] load;
    logic [2:0] n_consume;

    // A channel is free when empty or when its word leaves this cycle; that
    // lets one channel stream a word per cycle while its consumer is ready.
    // in_valid is deliberately not involved so the handshake has no loop.
    assign in_ready = !valid_q[select] || out_ready[select];
    assign accept   = in_valid && in_ready;

    // NOTE: every signal assigned in this block gets a default value first,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        consume   = valid_q & out_ready;
        load      = accept ? (4'b0001 << select) : 4'b0000;
        n_consume = '0;
        for (int k = 0; k < 4; k++) begin
            n_consume = n_consume + {2'b00, consume[k]};
            data_d[k] = load[k] ? in_data : data_q[k];
        end
        // A load on the same cycle as a consume keeps the channel valid.
        valid_d = (valid_q & ~consume) | load;
        // Truncation to CNT_WIDTH gives the required modulo wrap.
        cnt_d   = cnt_q + CNT_WIDTH'(n_consume);
    end

    // NOTE: state registers update with non-blocking assignments so every
    // flop samples its next-state value from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the channel data registers are reset as well, because the
            // outputs must read zero after reset, not just be marked invalid.
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign output_1  = data_q[0];
    assign output_2  = data_q[1];
    assign output_3  = data_q[2];
    assign output_4  = data_q[3];
    assign out_valid = valid_q;
    assign delivered = cnt_q;

endmodule
